// File: rtl/y_scale_tbl_writer.sv
// Purpose : runtime loader for the vertical-scale coefficient RAM; assembles 2-byte LE entries, checks trailing XOR byte.
// Latency : 3 cycles per entry minimum (LO accept, HI accept, WRITE strobe); checksum byte accepted after the last write.
// Backpr. : s_ready only in LO/HI/CSUM; state holds indefinitely while s_valid=0; start aborts/restarts from any state.
//
// Ports:
//   clk, tb_rst (async, active-high)  - clock and reset
//   start                             - one-cycle pulse, begins (or restarts) a load
//   s_byte/s_valid/s_ready            - byte stream in
//   wr_en/wr_addr/wr_data             - RAM write port; addr/data qualified only by wr_en
//   busy/done/err                     - load status to control logic
module y_scale_tbl_writer #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  start,
    input  logic [7:0]            s_byte,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LO    = 3'd1,
        ST_HI    = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [7:0]            lo_q, lo_d;
    logic [7:0]            acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic        xfer;
    logic [15:0] full_word;
    logic        hi_bad;

    // Ready and write strobe are pure decodes of the registered state, so
    // both drop immediately with an asynchronous reset.
    assign s_ready = (state_q == ST_LO) || (state_q == ST_HI) || (state_q == ST_CSUM);
    assign wr_en   = (state_q == ST_WRITE);
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

    assign xfer      = s_valid && s_ready;
    assign full_word = {s_byte, lo_q};
    // Any bit of the assembled word at or above DATA_WIDTH is a format
    // error; with DATA_WIDTH=16 the shift empties the word and never flags.
    assign hi_bad    = (full_word >> DATA_WIDTH) != 16'd0;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;

        if (start) begin
            // start wins over a same-cycle transfer: the byte is left on the bus.
            state_d = ST_LO;
            count_d = '0;
            acc_d   = 8'd0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LO: begin
                    if (xfer) begin
                        lo_d    = s_byte;
                        acc_d   = acc_q ^ s_byte;
                        state_d = ST_HI;
                    end
                end
                ST_HI: begin
                    if (xfer) begin
                        acc_d     = acc_q ^ s_byte;
                        wr_data_d = full_word[DATA_WIDTH-1:0];
                        wr_addr_d = count_q;
                        if (hi_bad) begin
                            err_d = 1'b1;
                        end
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Leaving for CSUM before incrementing keeps the counter
                    // from ever wrapping within a load.
                    if (count_q == {ADDR_WIDTH{1'b1}}) begin
                        state_d = ST_CSUM;
                    end else begin
                        count_d = count_q + 1'b1;
                        state_d = ST_LO;
                    end
                end
                ST_CSUM: begin
                    if (xfer) begin
                        if (s_byte != acc_q) begin
                            err_d = 1'b1;
                        end
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end
                end
                default: begin
                    // IDLE and FIN: ignore the stream, wait for start.
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            lo_q      <= 8'd0;
            acc_q     <= 8'd0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_y_scale_tbl_writer.sv
// Purpose : scoreboard bench for y_scale_tbl_writer (default 11-bit address, 15-bit data).
// Latency : expected writes are queued by the driver and popped by a negedge monitor on every wr_en.
// Backpr. : driver optionally inserts random idle cycles (~30% valid duty) before each byte.
module tb_y_scale_tbl_writer;

    localparam int AW = 11;
    localparam int DW = 15;
    localparam int N  = 2048;

    logic          clk;
    logic          tb_rst;
    logic          start;
    logic [7:0]    s_byte;
    logic          s_valid;
    logic          s_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err;

    y_scale_tbl_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .tb_rst  (tb_rst),
        .start   (start),
        .s_byte  (s_byte),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   t0     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!tb_rst && wr_en) begin
            exp_t e;
            chk("s_ready_in_write", {31'd0, s_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {21'd0, wr_addr}, {21'd0, e.a});
                chk("wr_data", {17'd0, wr_data}, {17'd0, e.d});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit bp);
        int guard;
        if (bp) begin
            while ($urandom_range(0, 99) >= 30) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_byte  = b;
        s_valid = 1'b1;
        guard   = 0;
        while (!s_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!s_ready) begin
            chk("s_ready_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0    = cyc;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("ready_after_start", {31'd0, s_ready}, 32'd1);
    endtask

    // Entry i = i, sent as {i[7:0], i[14:8]}. bad >= 0 replaces that entry's
    // high byte with 0x80, so the RAM gets only the low byte.
    task automatic send_entries(input int first, input int last, input int bad, input bit bp);
        logic [15:0] v;
        exp_t        e;
        for (int i = first; i <= last; i++) begin
            v   = 16'(i);
            e.a = v[AW-1:0];
            e.d = (i == bad) ? {7'd0, v[7:0]} : v[DW-1:0];
            exp_q.push_back(e);
            send_byte(v[7:0], bp);
            if (i == bad) begin
                chk("err_before_bad_hi", {31'd0, err}, 32'd0);
                send_byte(8'h80, bp);
                chk("err_on_bad_hi", {31'd0, err}, 32'd1);
            end else begin
                send_byte(v[15:8], bp);
            end
        end
    endtask

    task automatic finish_load(input string tag, input logic [7:0] csum, input bit bp,
                               input bit exp_err, input bit chk_time);
        send_byte(csum, bp);
        if (chk_time) chk({tag, "_cycles"}, cyc - t0, 32'd6145);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, "_writes_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        tb_rst  = 1'b1;
        start   = 1'b0;
        s_byte  = 8'd0;
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_wr_addr", {21'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {17'd0, wr_data}, 32'd0);
        tb_rst = 1'b0;
        @(posedge clk); #1;

        // Idle writer ignores the stream.
        s_byte = 8'h5A; s_valid = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b0;

        // Full load: lo bytes cover 0..255 eight times, hi bytes 0..7 256
        // times each, so the XOR of the stream is 0x00.
        pulse_start();
        send_entries(0, N - 1, -1, 1'b0);
        finish_load("full", 8'h00, 1'b0, 1'b0, 1'b1);

        // Checksum off by one bit.
        pulse_start();
        send_entries(0, N - 1, -1, 1'b0);
        finish_load("csum_bad", 8'h01, 1'b0, 1'b1, 1'b1);

        // Entry 5 high byte 0x80: stream XOR becomes 0x80, so the checksum
        // matches and err comes only from the format error.
        pulse_start();
        send_entries(0, N - 1, 5, 1'b0);
        finish_load("fmt", 8'h80, 1'b0, 1'b1, 1'b1);

        // Back-pressure.
        pulse_start();
        send_entries(0, N - 1, -1, 1'b1);
        finish_load("bp", 8'h00, 1'b1, 1'b0, 1'b0);

        // Restart: 100 entries with a format error, then start while a byte
        // is offered in LO; that byte must not be consumed.
        pulse_start();
        send_entries(0, 99, 5, 1'b0);
        @(posedge clk); #1;
        chk("rs_err_before", {31'd0, err}, 32'd1);
        chk("rs_ready_before", {31'd0, s_ready}, 32'd1);
        s_byte  = 8'h55;
        s_valid = 1'b1;
        pulse_start();
        s_valid = 1'b0;
        chk("rs_err_cleared", {31'd0, err}, 32'd0);
        send_entries(0, N - 1, -1, 1'b0);
        finish_load("restart", 8'h00, 1'b0, 1'b0, 1'b1);

        // Reset asserted between edges while in HI.
        pulse_start();
        send_entries(0, 3, -1, 1'b0);
        send_byte(8'h04, 1'b0);
        chk("mid_wr_addr", {21'd0, wr_addr}, 32'd3);
        chk("mid_ready", {31'd0, s_ready}, 32'd1);
        #3;
        tb_rst = 1'b1;
        #1;
        chk("arst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_wr_addr", {21'd0, wr_addr}, 32'd0);
        chk("arst_wr_data", {17'd0, wr_data}, 32'd0);
        chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
        @(posedge clk); #1;
        tb_rst = 1'b0;
        exp_q.delete();
        s_byte  = 8'h00;
        s_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("post_rst_ready", {31'd0, s_ready}, 32'd0);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        s_valid = 1'b0;
        chk("post_rst_done", {31'd0, done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/y_scale_tbl_writer.md
# y_scale_tbl_writer

Runtime loader for the vertical-scale coefficient table. It accepts a byte stream over a valid/ready interface and assembles 2-byte little-endian entries. Each entry is written sequentially into a RAM that replaces the init-file y-scale ROM, so the table can be reprogrammed without rebuilding the bitstream. After the last entry it checks a trailing XOR checksum byte and reports done/error to the control logic.

## Interface
Parameters:
- ADDR_WIDTH, 11, table address width; the table holds 2**ADDR_WIDTH entries.
- DATA_WIDTH, 15, entry width; legal range 9..16.

Ports:
- clk, in, 1, clock; all logic is rising-edge.
- tb_rst, in, 1, reset: asynchronous, active-high.
- start, in, 1, single-cycle pulse that begins a load; honoured in every state.
- s_byte, in, 8, stream byte.
- s_valid, in, 1, stream byte valid.
- s_ready, out, 1, writer can accept a byte.
- wr_en, out, 1, RAM write strobe; one cycle per entry.
- wr_addr, out, ADDR_WIDTH, RAM write address.
- wr_data, out, DATA_WIDTH, RAM write data.
- busy, out, 1, high from start until the checksum byte is accepted.
- done, out, 1, high after a completed load; held until the next start or reset.
- err, out, 1, sticky error (format or checksum); cleared by start or reset.

## Operation
- States: IDLE, LO, HI, WRITE, CSUM, FIN.
- A byte transfers on a rising edge with s_valid && s_ready. s_ready is 1 only in LO, HI and CSUM.
- start, from any state:
  - next state is LO;
  - address counter, XOR accumulator, done and err clear;
  - busy goes 1.
  - start takes priority over any transfer in the same cycle; that byte is not consumed.
- LO: the accepted byte goes to lo_reg, is XORed into the accumulator, then the state moves to HI.
- HI: the accepted byte is XORed into the accumulator.
  - wr_data = {s_byte[DATA_WIDTH-9:0], lo_reg}, truncated to DATA_WIDTH.
  - If s_byte[7:DATA_WIDTH-8] is nonzero, err is set; the truncated value is still written.
  - Next state is WRITE.
- WRITE: wr_en=1 for exactly this cycle, with wr_addr = current count.
  - If count equals 2**ADDR_WIDTH-1, next state is CSUM; otherwise count+1 and the next state is LO.
- CSUM: the accepted byte is compared with the accumulator. A mismatch sets err.
  - busy goes 0, done goes 1, next state is FIN.
- FIN and IDLE: s_ready=0, all stream bytes are ignored, and the state waits for start.
- wr_addr and wr_data hold their last values outside WRITE. The RAM qualifies them only with wr_en.
- The address counter is ADDR_WIDTH wide. It never wraps during a load, because the CSUM transition happens before any increment past the top.

## Timing
- Reset values:
  - state IDLE;
  - s_ready, wr_en, busy, done, err all 0;
  - wr_addr 0, wr_data 0.
- The cycle after a start pulse, s_ready=1 and busy=1.
- Per entry:
  - LO accept, HI accept, WRITE: a minimum of 3 cycles.
  - wr_en asserts on the clock edge that accepts the HI byte and lasts 1 cycle.
  - s_ready=0 during WRITE.
- Back-pressure: the writer holds state while s_valid=0, with no timeout.
- A full load takes at least 3*2**ADDR_WIDTH + 1 cycles after start. With the defaults that is 6145 cycles.
- done and err update on the same edge that accepts the checksum byte. busy falls on that edge.
- A format error raises err on the edge that accepts the offending HI byte; it does not wait for CSUM.
- If tb_rst is asserted mid-load, all outputs return to reset values immediately. RAM contents are whatever was already written, and the table is invalid until a new load completes.
- If start arrives mid-load, the load aborts and restarts at address 0 on the next cycle. An entry in WRITE that cycle is still strobed, because wr_en was registered on the prior edge.

## Test plan
- Full load, default parameters: entry i = i. Stream 4096 bytes as {i[7:0], i[14:8]} with s_valid held at 1, plus the correct XOR. Required:
  - 2048 wr_en pulses with addresses 0..2047 and data = address;
  - done=1, err=0;
  - busy low after exactly 6145 cycles.
- Checksum mismatch: same stream with the checksum byte XOR 0x01. Required: all 2048 writes occur, then done=1 and err=1.
- Format error: entry 5 has its high byte at 0x80. Required:
  - err=1 on the edge accepting that byte;
  - wr_data at address 5 = 0x0000 | lo byte;
  - the load continues to done=1 with err still 1.
- Back-pressure: random s_valid duty of roughly 30%. Required:
  - data and addresses are identical to the full-load case;
  - no byte is lost or duplicated;
  - s_ready=0 in every WRITE cycle.
- Restart: pulse start after 100 entries, then send a full valid load. Required:
  - the next wr_addr is 0;
  - err is cleared;
  - the final state is done=1, err=0;
  - a byte presented in the same cycle as start is not consumed.
- Reset mid-load: assert tb_rst asynchronously between clock edges during HI. Required:
  - outputs drop to reset values without waiting for clk;
  - bytes after reset release are ignored until start.
